// File: rtl/madd_approx_seq.sv
// Sequential shift-add approximate multiply-add: out_res = a*b + c, or a*b + last result in MAC mode.
// Optional MADD_ERR_MON_EN adds a shadow accumulator that tracks the magnitude of dropped partial products.
module madd_approx_seq #(
  parameter int N = 4,
  parameter int APPROX_COLS = 0,
  parameter logic [2*N-1:0] ERR_THRESH = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [N-1:0]   in_c,
  input  logic           in_acc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_res,
  output logic           out_ovf,
  output logic [2*N-1:0] err_mag,
  output logic           err_flag
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ovf_run;
  logic [W-1:0]  res_q;
  logic          ovf_q;

  logic [N-1:0]  mask;
  logic [N-1:0]  b_sh;
  logic          b_bit;
  logic [W-1:0]  pp_apx;
  logic [W:0]    sum;
  logic          last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign last_step = (cnt == CW'(N));

  // Column mask for row j=cnt: bit i survives only when i+j reaches APPROX_COLS
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i + int'(cnt)) >= APPROX_COLS;
    end
  end

  // Current row's approximate partial product and the running sum with carry
  always_comb begin
    b_sh   = b_q >> cnt;
    b_bit  = b_sh[0];
    pp_apx = '0;
    if (b_bit) begin
      pp_apx = {{N{1'b0}}, a_q & mask} << cnt;
    end
    sum = {1'b0, acc} + {1'b0, pp_apx};
  end

  // Control FSM and datapath; cnt==N is a finalize cycle that publishes the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf_run <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc     <= in_acc ? res_q : {{N{1'b0}}, in_c};
            cnt     <= '0;
            ovf_run <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (last_step) begin
            res_q <= acc;
            ovf_q <= ovf_run;
            state <= DONE;
          end else begin
            acc     <= sum[W-1:0];
            ovf_run <= ovf_run | sum[W];
            cnt     <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MADD_ERR_MON_EN
  logic [W-1:0] err_acc;
  logic [W-1:0] err_q;
  logic         flag_q;
  logic [W-1:0] pp_drop;

  // Dropped bits of the current row; exact minus approx equals their sum
  always_comb begin
    pp_drop = '0;
    if (b_bit) begin
      pp_drop = {{N{1'b0}}, a_q & ~mask} << cnt;
    end
  end

  // Shadow error accumulator, published alongside the result
  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            err_acc <= '0;
          end
        end
        BUSY: begin
          if (last_step) begin
            err_q  <= err_acc;
            flag_q <= (err_acc > ERR_THRESH);
          end else begin
            err_acc <= err_acc + pp_drop;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_mag  = err_q;
  assign err_flag = flag_q;
`else
  assign err_mag  = '0;
  assign err_flag = 1'b0;
`endif

endmodule
